mac_dot_seq: RTL and testbench
==============================

// Module: mac_dot_seq
// PURPOSE
//   Sequential dot-product controller placed directly upstream of mac_unit.
//   Accepts a bias, then N_TERMS (x, w) pairs over a valid/ready stream.
//   For each pair it drives mac_unit with op1=x, op2=w, op3=running accumulator.
//   It registers total_result back as the new accumulator and returns
//   bias + sum(x*w) on a valid/ready output with sticky overflow flags.
// PARAMETERS
//   N_TERMS  4                    number of (x,w) products per dot product, >=1
//   CNT_W    $clog2(N_TERMS+1)    term counter width (derived, do not override)
// PORTS
//   clk           in   1   rising-edge clock
//   resetn        in   1   asynchronous active-low reset
//   start         in   1   1-cycle request to begin; sampled only in IDLE
//   bias          in   32  signed initial accumulator value, captured with start
//   clear         in   1   synchronous abort: return to IDLE from any state
//   in_valid      in   1   x_in/w_in valid
//   in_ready      out  1   block accepts a pair this cycle
//   x_in          in   32  signed multiplicand
//   w_in          in   32  signed multiplier (weight)
//   mac_op1       out  32  to mac_unit op1
//   mac_op2       out  32  to mac_unit op2
//   mac_op3       out  32  to mac_unit op3 (accumulator)
//   mac_result    in   32  from mac_unit total_result
//   mac_ovf_mul   in   1   from mac_unit ovf_mul
//   mac_ovf_add   in   1   from mac_unit ovf_add
//   out_valid     out  1   result available
//   out_ready     in   1   consumer takes result
//   out_data      out  32  signed final accumulator
//   out_zero      out  1   out_data == 0
//   out_ovf_mul   out  1   any product overflowed during this run (sticky)
//   out_ovf_add   out  1   any addition overflowed during this run (sticky)
//   busy          out  1   state != IDLE
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE; acc, cnt, sticky flags = 0.
//     All outputs are 0, including out_data, out_valid, in_ready and busy.
//   FSM states: IDLE -> ACCUM -> DONE -> IDLE.
//   IDLE: in_ready=0, out_valid=0. On start=1: acc<=bias, cnt<=0, stickies<=0, go ACCUM.
//   ACCUM: in_ready=1. mac_op1=x_in, mac_op2=w_in, mac_op3=acc (combinational).
//     On in_valid&&in_ready: acc<=mac_result; ovf_mul_s|=mac_ovf_mul;
//     ovf_add_s|=mac_ovf_add; cnt<=cnt+1.
//     The accept that makes cnt reach N_TERMS (cnt==N_TERMS-1 before it) goes to DONE.
//     in_valid=0 cycles stall; acc and cnt hold.
//   Outside ACCUM: mac_op1=mac_op2=0, mac_op3=acc. MAC flags are ignored.
//   DONE: out_valid=1; out_data=acc; out_zero=(acc==0); out_ovf_*=stickies.
//     Outputs stay stable until out_valid&&out_ready; the next cycle is IDLE with out_valid=0.
//     out_data/flags hold their last value in IDLE until the next start.
//   Latency: one accepted pair per cycle. With in_valid held high, out_valid rises
//     N_TERMS+1 cycles after the start edge.
//   Arithmetic: 32-bit two's-complement wrap, as produced by mac_unit. No saturation.
//     Overflow is reported only via the sticky flags.
//   start outside IDLE is ignored, including start coincident with the DONE handshake.
//   clear has priority over start, in_valid and out_ready.
//     clear: state<=IDLE, cnt<=0, stickies<=0, out_valid=0 next cycle; acc is unchanged.
//   Reset mid-run discards all progress; no partial result is emitted.
// TESTING (bench instantiates mac_dot_seq + mac_unit, N_TERMS=4)
//   bias=10, pairs (2,3),(4,5),(-1,6),(0,7) back-to-back
//     -> out_data=30, out_zero=0, out_ovf_*=0, out_valid 5 cycles after start.
//   Same run with in_valid low 3 cycles between pairs and out_ready low 4 cycles
//     -> identical result; out_data stable while out_valid=1 && !out_ready.
//   bias=32'h7FFFFFFF, pairs (1,1),(0,0),(0,0),(0,0)
//     -> out_data=32'h80000000, out_ovf_add=1, out_ovf_mul=0.
//   bias=0, pairs (32'h10000,32'h10000),(0,0)x3 -> out_ovf_mul=1.
//     Next run with bias=0 and small pairs -> out_ovf_mul=0 (stickies cleared on start).
//   bias=0, pairs (3,4),(-2,6),(5,0),(0,9) -> out_data=0, out_zero=1.
//   resetn=0 after 2 accepted pairs -> all outputs 0 immediately, FSM in IDLE.
//     Repeat with clear=1 -> IDLE next cycle, out_valid never asserted.

Source files
------------

// File: rtl/mac_dot_seq.sv
// -----------------------------------------------------------------------------
// mac_dot_seq
//   Sequential dot-product controller that sits in front of a mac_unit.
//   A run begins with start (bias captured as the initial accumulator), then
//   accepts N_TERMS (x, w) pairs over a valid/ready stream, one per cycle.
//   Each accepted pair is pushed through mac_unit as x*w + acc, and the
//   returned total_result becomes the new accumulator. The final accumulator
//   is presented on a valid/ready output with sticky overflow flags.
//
// Ports
//   clk, resetn             clock, asynchronous active-low reset
//   start, bias             begin a run (IDLE only), initial accumulator
//   clear                   synchronous abort back to IDLE, highest priority
//   in_valid/in_ready       input pair handshake, x_in / w_in payload
//   mac_op1/op2/op3         operands driven to mac_unit
//   mac_result, mac_ovf_*   results returned from mac_unit
//   out_valid/out_ready     result handshake
//   out_data, out_zero      final accumulator and its zero flag
//   out_ovf_mul/out_ovf_add sticky overflow flags for the run
//   busy                    controller is not idle
// -----------------------------------------------------------------------------
module mac_dot_seq #(
  parameter  int N_TERMS = 4,
  localparam int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic [31:0] mac_op1,
  output logic [31:0] mac_op2,
  output logic [31:0] mac_op3,
  input  logic [31:0] mac_result,
  input  logic        mac_ovf_mul,
  input  logic        mac_ovf_add,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic        out_ovf_mul,
  output logic        out_ovf_add,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

  logic [1:0]       state_r,   state_nxt_s;
  logic [31:0]      acc_r,     acc_nxt_s;
  logic [CNT_W-1:0] cnt_r,     cnt_nxt_s;
  logic             ovf_mul_r, ovf_mul_nxt_s;
  logic             ovf_add_r, ovf_add_nxt_s;
  logic             zero_r,    zero_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             accum_s;

  assign accum_s = (state_r == ST_ACCUM);

  // mac_unit operands: only the live pair is forwarded while accumulating,
  // so the multiplier sees zeros outside ACCUM; op3 always tracks acc.
  assign mac_op1 = accum_s ? x_in : 32'd0;
  assign mac_op2 = accum_s ? w_in : 32'd0;
  assign mac_op3 = acc_r;

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign out_data    = acc_r;
  assign out_zero    = zero_r;
  assign out_ovf_mul = ovf_mul_r;
  assign out_ovf_add = ovf_add_r;

  // Next-state and datapath update; clear overrides every other input.
  always_comb begin
    state_nxt_s   = state_r;
    acc_nxt_s     = acc_r;
    cnt_nxt_s     = cnt_r;
    ovf_mul_nxt_s = ovf_mul_r;
    ovf_add_nxt_s = ovf_add_r;
    zero_nxt_s    = zero_r;
    if (clear) begin
      // Abort keeps acc; only control state and stickies are dropped.
      state_nxt_s   = ST_IDLE;
      cnt_nxt_s     = '0;
      ovf_mul_nxt_s = 1'b0;
      ovf_add_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s   = ST_ACCUM;
            acc_nxt_s     = bias;
            cnt_nxt_s     = '0;
            ovf_mul_nxt_s = 1'b0;
            ovf_add_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          // in_ready is always high here, so in_valid alone is the accept.
          if (in_valid) begin
            acc_nxt_s     = mac_result;
            ovf_mul_nxt_s = ovf_mul_r | mac_ovf_mul;
            ovf_add_nxt_s = ovf_add_r | mac_ovf_add;
            cnt_nxt_s     = cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_nxt_s = ST_DONE;
              zero_nxt_s  = (mac_result == 32'd0);
            end else begin
              state_nxt_s = ST_ACCUM;
            end
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even on the handshake.
          if (out_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs decoded from next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      acc_r       <= 32'd0;
      cnt_r       <= '0;
      ovf_mul_r   <= 1'b0;
      ovf_add_r   <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ovf_mul_r   <= ovf_mul_nxt_s;
      ovf_add_r   <= ovf_add_nxt_s;
      zero_r      <= zero_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_ACCUM);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_seq
//   Directed bench for mac_dot_seq (N_TERMS=4) with a behavioural mac_unit
//   (op1*op2 + op3, 32-bit wrap, signed overflow flags) wired in place.
//   Inputs are driven on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mac_dot_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] bias;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic [31:0] mac_op1;
  logic [31:0] mac_op2;
  logic [31:0] mac_op3;
  logic [31:0] mac_result;
  logic        mac_ovf_mul;
  logic        mac_ovf_add;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_ovf_mul;
  logic        out_ovf_add;
  logic        busy;

  int checks;
  int failures;
  int cyc;

  mac_dot_seq #(.N_TERMS(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .bias(bias), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_op3(mac_op3),
    .mac_result(mac_result), .mac_ovf_mul(mac_ovf_mul), .mac_ovf_add(mac_ovf_add),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ovf_mul(out_ovf_mul), .out_ovf_add(out_ovf_add),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mac_unit: full signed product, wrapped sum, overflow flags.
  logic signed [63:0] a64_s, b64_s, prod64_s;
  logic [31:0] p32_s, sum_s;
  always_comb begin
    a64_s       = {{32{mac_op1[31]}}, mac_op1};
    b64_s       = {{32{mac_op2[31]}}, mac_op2};
    prod64_s    = a64_s * b64_s;
    p32_s       = prod64_s[31:0];
    sum_s       = p32_s + mac_op3;
    mac_result  = sum_s;
    mac_ovf_mul = (prod64_s[63:32] != {32{p32_s[31]}});
    mac_ovf_add = (p32_s[31] == mac_op3[31]) && (sum_s[31] != p32_s[31]);
  end

  // One full run: start, four pairs (optional idle gap between them), wait
  // for out_valid, hold out_ready low for rdy_wait cycles, then handshake.
  task automatic do_run(input logic [31:0] b, input logic [3:0][31:0] xs,
                        input logic [3:0][31:0] ws, input int gap, input int rdy_wait,
                        input logic start_at_done,
                        output logic [31:0] d, output logic z, output logic om,
                        output logic oa, output int lat, output int unstable,
                        output int timeout);
    int t0;
    int n;
    unstable = 0;
    timeout  = 0;
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gap > 0 && i > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      if (!in_ready) timeout++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    x_in     = 32'd0;
    w_in     = 32'd0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout++;
    lat = cyc - t0;
    d   = out_data;
    z   = out_zero;
    om  = out_ovf_mul;
    oa  = out_ovf_add;
    repeat (rdy_wait) begin
      @(negedge clk);
      if (out_data !== d || out_valid !== 1'b1) unstable++;
    end
    out_ready = 1'b1;
    start     = start_at_done;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b want 0 0 0", out_valid, in_ready, busy);
    end
    checks++;
    if (out_data !== 32'd0 || out_zero !== 1'b0 || out_ovf_mul !== 1'b0 || out_ovf_add !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got data=%h zero=%b om=%b oa=%b want 0", out_data, out_zero, out_ovf_mul, out_ovf_add);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] d; logic z, om, oa; int lat, uns, to;
    do_run(32'd10, {32'd0, 32'hFFFFFFFF, 32'd4, 32'd2}, {32'd7, 32'd6, 32'd5, 32'd3},
           0, 0, 1'b1, d, z, om, oa, lat, uns, to);
    checks++;
    if (d !== 32'd30 || z !== 1'b0) begin
      failures++;
      $display("FAIL basic_data: got %0d zero=%b want 30 zero=0", $signed(d), z);
    end
    checks++;
    if (om !== 1'b0 || oa !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags: got om=%b oa=%b want 0 0", om, oa);
    end
    checks++;
    if (lat !== 5 || to !== 0) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles (timeouts %0d) want 5", lat, to);
    end
    // start was raised with the handshake: must be ignored.
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_start_ignored: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 32'd30 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got data=%0d busy=%b want 30 0", out_data, busy);
    end
  endtask

  task automatic test_stall;
    logic [31:0] d; logic z, om, oa; int lat, uns, to;
    do_run(32'd10, {32'd0, 32'hFFFFFFFF, 32'd4, 32'd2}, {32'd7, 32'd6, 32'd5, 32'd3},
           3, 4, 1'b0, d, z, om, oa, lat, uns, to);
    checks++;
    if (d !== 32'd30 || z !== 1'b0 || om !== 1'b0 || oa !== 1'b0 || to !== 0) begin
      failures++;
      $display("FAIL stall_data: got %0d z=%b om=%b oa=%b to=%0d want 30 0 0 0 0", $signed(d), z, om, oa, to);
    end
    checks++;
    if (uns !== 0) begin
      failures++;
      $display("FAIL stall_stable: got %0d unstable cycles want 0", uns);
    end
  endtask

  task automatic test_ovf_add;
    logic [31:0] d; logic z, om, oa; int lat, uns, to;
    do_run(32'h7FFFFFFF, {32'd0, 32'd0, 32'd0, 32'd1}, {32'd0, 32'd0, 32'd0, 32'd1},
           0, 0, 1'b0, d, z, om, oa, lat, uns, to);
    checks++;
    if (d !== 32'h80000000 || oa !== 1'b1 || om !== 1'b0) begin
      failures++;
      $display("FAIL ovf_add: got data=%h om=%b oa=%b want 80000000 0 1", d, om, oa);
    end
  endtask

  task automatic test_ovf_mul;
    logic [31:0] d; logic z, om, oa; int lat, uns, to;
    do_run(32'd0, {32'd0, 32'd0, 32'd0, 32'h10000}, {32'd0, 32'd0, 32'd0, 32'h10000},
           0, 0, 1'b0, d, z, om, oa, lat, uns, to);
    checks++;
    if (om !== 1'b1 || oa !== 1'b0 || d !== 32'd0) begin
      failures++;
      $display("FAIL ovf_mul: got data=%h om=%b oa=%b want 0 1 0", d, om, oa);
    end
    do_run(32'd0, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd1, 32'd1, 32'd1},
           0, 0, 1'b0, d, z, om, oa, lat, uns, to);
    checks++;
    if (om !== 1'b0 || d !== 32'd10) begin
      failures++;
      $display("FAIL sticky_cleared: got data=%0d om=%b want 10 0", d, om);
    end
  endtask

  task automatic test_zero;
    logic [31:0] d; logic z, om, oa; int lat, uns, to;
    do_run(32'd0, {32'd0, 32'd5, 32'hFFFFFFFE, 32'd3}, {32'd9, 32'd0, 32'd6, 32'd4},
           0, 0, 1'b0, d, z, om, oa, lat, uns, to);
    checks++;
    if (d !== 32'd0 || z !== 1'b1) begin
      failures++;
      $display("FAIL zero: got data=%0d zero=%b want 0 1", d, z);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; bias = 32'd10;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x_in = 32'd2; w_in = 32'd3;
    @(negedge clk);
    x_in = 32'd4; w_in = 32'd5;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b ready=%b valid=%b data=%h want 0 0 0 0", busy, in_ready, out_valid, out_data);
    end
    checks++;
    if (mac_op1 !== 32'd0 || mac_op3 !== 32'd0 || out_ovf_mul !== 1'b0 || out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_ops: got op1=%h op3=%h om=%b z=%b want 0", mac_op1, mac_op3, out_ovf_mul, out_zero);
    end
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear;
    int seen;
    @(negedge clk);
    start = 1'b1; bias = 32'd10;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; x_in = 32'd2; w_in = 32'd3;
    @(negedge clk);
    x_in = 32'd4; w_in = 32'd5;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: got busy=%b ready=%b want 0 0", busy, in_ready);
    end
    // acc survives the abort: 10 + 6 + 20.
    checks++;
    if (mac_op3 !== 32'd36 || mac_op1 !== 32'd0) begin
      failures++;
      $display("FAIL clear_acc: got op3=%0d op1=%0d want 36 0", mac_op3, mac_op1);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL clear_no_valid: got %0d cycles with out_valid want 0", seen);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    resetn = 1'b0; start = 1'b0; bias = 32'd0; clear = 1'b0;
    in_valid = 1'b0; x_in = 32'd0; w_in = 32'd0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_ovf_add();
    test_ovf_mul();
    test_zero();
    test_reset_mid();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
